r5p_tcl_arb: RTL and testbench

- Two-manager to one-subordinate arbiter for the TCL system bus.
- Lets the R5P Mouse core (manager 0) share its single instruction/GPR/load-store bus with a second manager (manager 1: debug port or DMA).
- Grants the bus per transfer with locking while a request is stalled, and routes the delayed read response back to the manager that issued it.
- Sits between the core's bus port and the memory/GPR/peripheral interconnect.

---
 rtl/r5p_tcl_pkg.sv | 37 +++
 rtl/r5p_tcl_arb_sel.sv | 29 ++
 rtl/r5p_tcl_arb.sv | 140 ++++++++++++++
 tb/tb_r5p_tcl_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/r5p_tcl_pkg.sv
// Shared TCL bus types for the R5P arbiter slice: manager index, request/response views.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package r5p_tcl_pkg;

  // Manager index; one bit covers the two-manager arbiter.
  typedef logic [0:0] mgr_t;

  // Default TCL widths used by the canonical struct views below.
  localparam int unsigned TCL_AW = 32;
  localparam int unsigned TCL_DW = 32;

  // Response arrives exactly this many cycles after the transfer cycle.
  localparam int unsigned TCL_RSP_LAT = 1;

  // Request phase as seen by a subordinate.
  typedef struct packed {
    logic                  vld;
    logic                  wen;
    logic [TCL_AW-1:0]     adr;
    logic [TCL_DW/8-1:0]   ben;
    logic [TCL_DW-1:0]     wdt;
  } tcl_req_t;

  // Response phase as seen by a manager.
  typedef struct packed {
    logic [TCL_DW-1:0] rdt;
    logic              err;
    logic              rdy;
  } tcl_rsp_t;

  // Round-robin choice on a tie: the manager that did not win last time.
  function automatic mgr_t rr_next(input mgr_t lst);
    return ~lst;
  endfunction

endpackage

// File: rtl/r5p_tcl_arb_sel.sv
// Winner selection for the TCL arbiter: lock, single-requester, RR or fixed-priority tie break.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller holds the lock while the subordinate stalls.
module r5p_tcl_arb_sel
  import r5p_tcl_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] i_vld,
  input  logic       i_lck,
  input  mgr_t       i_own,
  input  mgr_t       i_lst,
  output mgr_t       o_win
);

  // Locked bus keeps its owner; otherwise pick among the current requesters.
  always_comb begin
    o_win = i_own;
    if (!i_lck) begin
      case (i_vld)
        2'b01:   o_win = 1'b0;
        2'b10:   o_win = 1'b1;
        2'b11:   o_win = RR ? rr_next(i_lst) : 1'b0;
        default: o_win = i_own;
      endcase
    end
  end

endmodule

// File: rtl/r5p_tcl_arb.sv
// Two-manager to one-subordinate TCL arbiter; optional stats under R5P_TCL_ARB_STAT_EN.
// Latency: request and rdy paths are zero-cycle; response is routed one cycle after the transfer.
// Backpressure: a stalled winner locks the bus until its transfer completes; the loser sees rdy=0.
module r5p_tcl_arb
  import r5p_tcl_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter bit          RR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_vld,
  input  logic            m0_wen,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW/8-1:0] m0_ben,
  input  logic [DW-1:0]   m0_wdt,
  output logic [DW-1:0]   m0_rdt,
  output logic            m0_err,
  output logic            m0_rdy,
  input  logic            m1_vld,
  input  logic            m1_wen,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW/8-1:0] m1_ben,
  input  logic [DW-1:0]   m1_wdt,
  output logic [DW-1:0]   m1_rdt,
  output logic            m1_err,
  output logic            m1_rdy,
  output logic            s_vld,
  output logic            s_wen,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_ben,
  output logic [DW-1:0]   s_wdt,
  input  logic [DW-1:0]   s_rdt,
  input  logic            s_err,
  input  logic            s_rdy
`ifdef R5P_TCL_ARB_STAT_EN
  ,
  output logic [15:0]     sts_cnt0,
  output logic [15:0]     sts_cnt1,
  output logic [15:0]     sts_stl
`endif
);

  typedef struct packed {
    logic            vld;
    logic            wen;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] ben;
    logic [DW-1:0]   wdt;
  } req_t;

  logic r_lck;
  mgr_t r_own;
  mgr_t r_lst;
  mgr_t r_rsp;
  logic r_rsv;

  mgr_t w_win;
  req_t w_req [2];
  req_t w_sel;
  logic w_xfr;

  assign w_req[0] = '{vld: m0_vld, wen: m0_wen, adr: m0_adr, ben: m0_ben, wdt: m0_wdt};
  assign w_req[1] = '{vld: m1_vld, wen: m1_wen, adr: m1_adr, ben: m1_ben, wdt: m1_wdt};

  r5p_tcl_arb_sel #(.RR(RR)) u_sel (
    .i_vld ({m1_vld, m0_vld}),
    .i_lck (r_lck),
    .i_own (r_own),
    .i_lst (r_lst),
    .o_win (w_win)
  );

  assign w_sel = w_req[w_win];

  // Request forwarding; handshakes are held off while reset is asserted.
  assign s_vld  = rst & w_sel.vld;
  assign s_wen  = w_sel.wen;
  assign s_adr  = w_sel.adr;
  assign s_ben  = w_sel.ben;
  assign s_wdt  = w_sel.wdt;
  assign m0_rdy = rst & (w_win == 1'b0) & s_rdy;
  assign m1_rdy = rst & (w_win == 1'b1) & s_rdy;
  assign w_xfr  = s_vld & s_rdy;

  // Response goes to whoever owned the previous transfer; err only when a response is due.
  assign m0_rdt = (rst && r_rsp == 1'b0) ? s_rdt : '0;
  assign m1_rdt = (rst && r_rsp == 1'b1) ? s_rdt : '0;
  assign m0_err = rst & r_rsv & (r_rsp == 1'b0) & s_err;
  assign m1_err = rst & r_rsv & (r_rsp == 1'b1) & s_err;

  // Lock on a stalled grant, release on transfer or when the locked manager drops vld.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lck <= 1'b0;
      r_own <= 1'b0;
      r_lst <= 1'b1;
      r_rsp <= 1'b0;
      r_rsv <= 1'b0;
    end else if (w_xfr) begin
      r_lck <= 1'b0;
      r_lst <= w_win;
      r_rsp <= w_win;
      r_rsv <= 1'b1;
    end else begin
      r_rsv <= 1'b0;
      if (s_vld) begin
        r_lck <= 1'b1;
        r_own <= w_win;
      end else begin
        r_lck <= 1'b0;
      end
    end
  end

`ifdef R5P_TCL_ARB_STAT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;
  logic [15:0] r_stl;

  // Saturating per-manager transfer counts and manager-1 stall cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_stl  <= '0;
    end else begin
      if (w_xfr && w_win == 1'b0 && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_xfr && w_win == 1'b1 && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
      if (m1_vld && !m1_rdy && r_stl != 16'hFFFF)       r_stl  <= r_stl + 16'd1;
    end
  end

  assign sts_cnt0 = r_cnt0;
  assign sts_cnt1 = r_cnt1;
  assign sts_stl  = r_stl;
`endif

endmodule

// File: tb/tb_r5p_tcl_arb.sv
// Directed bench for r5p_tcl_arb: reset, round-robin, lock, fixed priority, response/error routing.
// Latency: checks sample at the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: s_rdy is driven directly to exercise stall and lock behaviour.
module tb_r5p_tcl_arb;

  localparam logic [31:0] A0 = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h8000_0010;
  localparam logic [31:0] W0 = 32'hA5A5_0000;
  localparam logic [31:0] W1 = 32'h5A5A_1111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_vld = 1'b0, m0_wen = 1'b0;
  logic        m1_vld = 1'b0, m1_wen = 1'b0;
  logic [31:0] m0_adr = A0, m1_adr = A1;
  logic [3:0]  m0_ben = 4'hF, m1_ben = 4'h3;
  logic [31:0] m0_wdt = W0, m1_wdt = W1;
  logic [31:0] s_rdt = '0;
  logic        s_err = 1'b0, s_rdy = 1'b0;

  logic [31:0] m0_rdt, m1_rdt, s_adr, s_wdt;
  logic        m0_err, m1_err, m0_rdy, m1_rdy, s_vld, s_wen;
  logic [3:0]  s_ben;

  logic [31:0] f_m0_rdt, f_m1_rdt, f_s_adr, f_s_wdt;
  logic        f_m0_err, f_m1_err, f_m0_rdy, f_m1_rdy, f_s_vld, f_s_wen;
  logic [3:0]  f_s_ben;

`ifdef R5P_TCL_ARB_STAT_EN
  logic [15:0] sts_cnt0, sts_cnt1, sts_stl;
  logic [15:0] f_sts_cnt0, f_sts_cnt1, f_sts_stl;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  r5p_tcl_arb #(.AW(32), .DW(32), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_vld(m0_vld), .m0_wen(m0_wen), .m0_adr(m0_adr), .m0_ben(m0_ben), .m0_wdt(m0_wdt),
    .m0_rdt(m0_rdt), .m0_err(m0_err), .m0_rdy(m0_rdy),
    .m1_vld(m1_vld), .m1_wen(m1_wen), .m1_adr(m1_adr), .m1_ben(m1_ben), .m1_wdt(m1_wdt),
    .m1_rdt(m1_rdt), .m1_err(m1_err), .m1_rdy(m1_rdy),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdt(s_rdt), .s_err(s_err), .s_rdy(s_rdy)
`ifdef R5P_TCL_ARB_STAT_EN
    , .sts_cnt0(sts_cnt0), .sts_cnt1(sts_cnt1), .sts_stl(sts_stl)
`endif
  );

  r5p_tcl_arb #(.AW(32), .DW(32), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_vld(m0_vld), .m0_wen(m0_wen), .m0_adr(m0_adr), .m0_ben(m0_ben), .m0_wdt(m0_wdt),
    .m0_rdt(f_m0_rdt), .m0_err(f_m0_err), .m0_rdy(f_m0_rdy),
    .m1_vld(m1_vld), .m1_wen(m1_wen), .m1_adr(m1_adr), .m1_ben(m1_ben), .m1_wdt(m1_wdt),
    .m1_rdt(f_m1_rdt), .m1_err(f_m1_err), .m1_rdy(f_m1_rdy),
    .s_vld(f_s_vld), .s_wen(f_s_wen), .s_adr(f_s_adr), .s_ben(f_s_ben), .s_wdt(f_s_wdt),
    .s_rdt(s_rdt), .s_err(s_err), .s_rdy(s_rdy)
`ifdef R5P_TCL_ARB_STAT_EN
    , .sts_cnt0(f_sts_cnt0), .sts_cnt1(f_sts_cnt1), .sts_stl(f_sts_stl)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both managers requesting; outputs must stay quiet.
    rst = 1'b0; m0_vld = 1'b1; m1_vld = 1'b1; s_rdy = 1'b1;
    s_rdt = 32'h1234_5678; s_err = 1'b1;
    nxt(); nxt(); smp();
    chk("rst_s_vld",  s_vld,  32'd0);
    chk("rst_m0_rdy", m0_rdy, 32'd0);
    chk("rst_m1_rdy", m1_rdy, 32'd0);
    chk("rst_m0_rdt", m0_rdt, 32'd0);
    chk("rst_m0_err", m0_err, 32'd0);
    chk("rst_fp_vld", f_s_vld, 32'd0);

    // A: first cycle after release, manager 0 wins the tie.
    nxt(); rst = 1'b1; s_err = 1'b0; s_rdt = '0; smp();
    chk("A_s_vld",  s_vld,  32'd1);
    chk("A_s_adr",  s_adr,  A0);
    chk("A_m0_rdy", m0_rdy, 32'd1);
    chk("A_m1_rdy", m1_rdy, 32'd0);

    // B: manager 1 read granted; m0 response routed.
    nxt(); s_rdt = 32'h1111_1111; smp();
    chk("B_s_adr",  s_adr,  A1);
    chk("B_m1_rdy", m1_rdy, 32'd1);
    chk("B_m0_rdy", m0_rdy, 32'd0);
    chk("B_m0_rdt", m0_rdt, 32'h1111_1111);
    chk("B_m1_rdt", m1_rdt, 32'd0);

    // C: back to m0; m1 read data returns to m1 only.
    nxt(); s_rdt = 32'hDEAD_BEEF; smp();
    chk("C_m0_rdy", m0_rdy, 32'd1);
    chk("C_m1_rdt", m1_rdt, 32'hDEAD_BEEF);
    chk("C_m0_rdt", m0_rdt, 32'd0);

    // D: m1 alone transfers, so last winner becomes m1.
    nxt(); m0_vld = 1'b0; s_rdt = '0; smp();
    chk("D_m1_rdy", m1_rdy, 32'd1);
    chk("D_s_ben",  s_ben,  32'h3);

    // E: m1 stalls alone, taking the lock.
    nxt(); s_rdy = 1'b0; smp();
    chk("E_s_adr",  s_adr,  A1);
    chk("E_m1_rdy", m1_rdy, 32'd0);
    chk("E_s_vld",  s_vld,  32'd1);

    // F, G: m0 requests, but the locked m1 keeps the bus.
    for (int i = 0; i < 2; i++) begin
      nxt(); m0_vld = 1'b1; smp();
      chk("lck_s_adr",  s_adr,  A1);
      chk("lck_m0_rdy", m0_rdy, 32'd0);
    end

    // H: stall ends, m1 completes.
    nxt(); s_rdy = 1'b1; smp();
    chk("H_m1_rdy", m1_rdy, 32'd1);
    chk("H_m0_rdy", m0_rdy, 32'd0);

    // I: m0 granted next, issuing a write.
    nxt(); m0_wen = 1'b1; smp();
    chk("I_m0_rdy", m0_rdy, 32'd1);
    chk("I_s_adr",  s_adr,  A0);
    chk("I_s_wen",  s_wen,  32'd1);
    chk("I_s_wdt",  s_wdt,  W0);

    // J: write response carries an error to m0 only.
    nxt(); m0_vld = 1'b0; m1_vld = 1'b0; m0_wen = 1'b0; s_err = 1'b1; smp();
    chk("J_m0_err", m0_err, 32'd1);
    chk("J_m1_err", m1_err, 32'd0);
    chk("J_s_vld",  s_vld,  32'd0);

    // K: no response due, error is suppressed.
    nxt(); smp();
    chk("K_m0_err", m0_err, 32'd0);
    chk("K_m1_err", m1_err, 32'd0);

    // L: m0 transfer leaves a response pending.
    nxt(); m0_vld = 1'b1; s_err = 1'b0; smp();
    chk("L_m0_rdy", m0_rdy, 32'd1);

    // M: reset lands on the response cycle; no error may escape.
    nxt(); rst = 1'b0; m0_vld = 1'b0; s_err = 1'b1; smp();
    chk("M_m0_err", m0_err, 32'd0);
    chk("M_m1_err", m1_err, 32'd0);

    // N: out of reset, the dropped response stays dropped.
    nxt(); rst = 1'b1; smp();
    chk("N_m0_err", m0_err, 32'd0);
    chk("N_m1_err", m1_err, 32'd0);

    // O..R: both requesting; RR instance restarts at m0, fixed priority always m0.
    nxt(); m0_vld = 1'b1; m1_vld = 1'b1; s_err = 1'b0; smp();
    chk("O_rr_m0_rdy", m0_rdy, 32'd1);
    chk("O_rr_m1_rdy", m1_rdy, 32'd0);
    chk("fp_m0_rdy", f_m0_rdy, 32'd1);
    chk("fp_m1_rdy", f_m1_rdy, 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt(); smp();
      chk("fp_m0_rdy", f_m0_rdy, 32'd1);
      chk("fp_m1_rdy", f_m1_rdy, 32'd0);
      chk("fp_s_adr",  f_s_adr,  A0);
    end

`ifdef R5P_TCL_ARB_STAT_EN
    // Counters: 5 m0 transfers, 2 m1 stall cycles, 3 m1 transfers.
    nxt(); rst = 1'b0; m0_vld = 1'b0; m1_vld = 1'b0;
    nxt(); rst = 1'b1; m0_vld = 1'b1; s_rdy = 1'b1;
    repeat (4) nxt();
    nxt(); m0_vld = 1'b0; m1_vld = 1'b1; s_rdy = 1'b0;
    nxt();
    nxt(); s_rdy = 1'b1;
    repeat (2) nxt();
    nxt(); m1_vld = 1'b0; smp();
    chk("sts_cnt0", sts_cnt0, 32'd5);
    chk("sts_cnt1", sts_cnt1, 32'd3);
    chk("sts_stl",  sts_stl,  32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
